gal_fuse_reader: RTL and testbench

GAL_FUSE_READER -- requirements
Module: gal_fuse_reader

---
 rtl/gal_pkg.sv | 19 +
 rtl/gal_fuse_row_packer.sv | 99 +++++++++
 rtl/gal_fuse_reader.sv | 138 +++++++++++++
 tb/tb_gal_fuse_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gal_pkg.sv
// Shared constants and FSM state type for the GAL fuse-map loader.
package gal_pkg;

  localparam int DEFAULT_FUSE_COUNT = 2194;
  localparam int DEFAULT_ROW_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    CHECK,
    FIN
  } state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/gal_fuse_row_packer.sv
// Packs masked fuse bytes LSB-first into fuse-RAM rows and issues one registered
// write strobe per completed (or flushed partial) row.
module gal_fuse_row_packer
  import gal_pkg::*;
#(
  parameter int FUSE_COUNT = DEFAULT_FUSE_COUNT,
  parameter int ROW_WIDTH  = DEFAULT_ROW_WIDTH,
  parameter int ADDR_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 byte_valid,
  input  logic                 byte_last,
  input  logic [7:0]           byte_data,
  input  logic                 flush,
  output logic [7:0]           masked_byte,
  output logic                 w_en,
  output logic [ADDR_W-1:0]    w_addr,
  output logic [ROW_WIDTH-1:0] w_data
);

  localparam int NB       = ceil_div(FUSE_COUNT, 8);
  localparam int BPR      = ROW_WIDTH / 8;
  localparam int IDX_W    = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int REM_BITS = FUSE_COUNT - 8 * (NB - 1);
  localparam logic [7:0] LAST_MASK = 8'((16'd1 << REM_BITS) - 16'd1);

  logic [ROW_WIDTH-1:0] row_q, row_d, row_fill;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]    row_cnt_q, row_cnt_d;
  logic                 w_en_q, w_en_d;
  logic [ADDR_W-1:0]    w_addr_q, w_addr_d;
  logic [ROW_WIDTH-1:0] w_data_q, w_data_d;

  // A new row starts from zero, so a flushed partial row is already zero-padded.
  always_comb begin
    masked_byte = byte_last ? (byte_data & LAST_MASK) : byte_data;
    row_fill    = (idx_q == '0) ? '0 : row_q;
    for (int i = 0; i < BPR; i++) begin
      if (idx_q == IDX_W'(i)) row_fill[i*8 +: 8] = masked_byte;
    end

    row_d     = row_q;
    idx_d     = idx_q;
    row_cnt_d = row_cnt_q;
    w_en_d    = 1'b0;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;

    if (clear) begin
      row_d     = '0;
      idx_d     = '0;
      row_cnt_d = '0;
      w_addr_d  = '0;
      w_data_d  = '0;
    end else if (byte_valid) begin
      row_d = row_fill;
      if (idx_q == IDX_W'(BPR - 1)) begin
        w_en_d    = 1'b1;
        w_addr_d  = row_cnt_q;
        w_data_d  = row_fill;
        row_cnt_d = row_cnt_q + 1'b1;
        idx_d     = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (flush && (idx_q != '0)) begin
      w_en_d    = 1'b1;
      w_addr_d  = row_cnt_q;
      w_data_d  = row_q;
      row_cnt_d = row_cnt_q + 1'b1;
      idx_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      idx_q     <= '0;
      row_cnt_q <= '0;
      w_en_q    <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
    end else begin
      row_q     <= row_d;
      idx_q     <= idx_d;
      row_cnt_q <= row_cnt_d;
      w_en_q    <= w_en_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
    end
  end

  assign w_en   = w_en_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;

endmodule

// File: rtl/gal_fuse_reader.sv
// Streams a JEDEC fuse map into fuse-RAM rows; GAL_FUSE_CHECKSUM_EN adds the
// 16-bit byte-sum checksum, its CHECK state and the ERR flag.
module gal_fuse_reader
  import gal_pkg::*;
#(
  parameter  int FUSE_COUNT = DEFAULT_FUSE_COUNT,
  parameter  int ROW_WIDTH  = DEFAULT_ROW_WIDTH,
  localparam int ROWS       = ceil_div(FUSE_COUNT, ROW_WIDTH),
  localparam int ADDR_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 C,
  input  logic                 RN,
  input  logic                 START,
  input  logic                 S_VALID,
  output logic                 S_READY,
  input  logic [7:0]           S_DATA,
  output logic                 W_EN,
  output logic [ADDR_W-1:0]    W_ADDR,
  output logic [ROW_WIDTH-1:0] W_DATA,
  input  logic [15:0]          EXP_CHECKSUM,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [15:0]          CHECKSUM,
  output logic                 ERR
);

  localparam int NB    = ceil_div(FUSE_COUNT, 8);
  localparam int CNT_W = $clog2(NB + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             accept, last_byte, pack_clear, pack_flush;
  logic [7:0]       masked_byte;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pack_clear = 1'b0;
    pack_flush = 1'b0;
    accept     = S_VALID && (state_q == LOAD);
    last_byte  = (byte_cnt_q == CNT_W'(NB - 1));

    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
          pack_clear = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (last_byte) state_d = FLUSH;
        end
      end
      FLUSH: begin
        pack_flush = 1'b1;
`ifdef GAL_FUSE_CHECKSUM_EN
        state_d = CHECK;
`else
        state_d = FIN;
`endif
      end
      CHECK:   state_d = FIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

`ifdef GAL_FUSE_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;
  logic        err_q, err_d;

  always_comb begin
    checksum_d = checksum_q;
    err_d      = err_q;
    if (pack_clear) begin
      checksum_d = '0;
      err_d      = 1'b0;
    end else if (accept) begin
      checksum_d = checksum_q + 16'(masked_byte);
    end else if (state_q == CHECK) begin
      err_d = (checksum_q != EXP_CHECKSUM);
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      checksum_q <= checksum_d;
      err_q      <= err_d;
    end
  end

  assign CHECKSUM = checksum_q;
  assign ERR      = err_q;
`else
  logic unused_checksum_inputs;
  assign unused_checksum_inputs = ^{EXP_CHECKSUM, masked_byte};
  assign CHECKSUM = '0;
  assign ERR      = 1'b0;
`endif

  assign S_READY = (state_q == LOAD);
  assign BUSY    = (state_q == LOAD) || (state_q == FLUSH) || (state_q == CHECK);
  assign DONE    = (state_q == FIN);

  gal_fuse_row_packer #(
    .FUSE_COUNT(FUSE_COUNT),
    .ROW_WIDTH (ROW_WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_packer (
    .clk        (C),
    .rst_n      (RN),
    .clear      (pack_clear),
    .byte_valid (accept),
    .byte_last  (last_byte),
    .byte_data  (S_DATA),
    .flush      (pack_flush),
    .masked_byte(masked_byte),
    .w_en       (W_EN),
    .w_addr     (W_ADDR),
    .w_data     (W_DATA)
  );

endmodule

// File: tb/tb_gal_fuse_reader.sv
// Randomized bench for gal_fuse_reader against a fuse-array reference model;
// expectations follow GAL_FUSE_CHECKSUM_EN when it is defined.
module tb_gal_fuse_reader;

  localparam int FC   = 2194;
  localparam int RW   = 32;
  localparam int NB   = (FC + 7) / 8;
  localparam int ROWS = (FC + RW - 1) / RW;
  localparam int AW   = $clog2(ROWS);
`ifdef GAL_FUSE_CHECKSUM_EN
  localparam bit CSUM_ON  = 1'b1;
  localparam int DONE_LAT = 3;
`else
  localparam bit CSUM_ON  = 1'b0;
  localparam int DONE_LAT = 2;
`endif

  logic          C = 1'b0;
  logic          RN = 1'b0;
  logic          START = 1'b0;
  logic          S_VALID = 1'b0;
  logic [7:0]    S_DATA = '0;
  logic [15:0]   EXP_CHECKSUM = '0;
  logic          S_READY, W_EN, BUSY, DONE, ERR;
  logic [AW-1:0] W_ADDR;
  logic [RW-1:0] W_DATA;
  logic [15:0]   CHECKSUM;

  int compareCount = 0;
  int mismatchCount = 0;
  int wenCount = 0;

  logic [AW-1:0] wAddrQ[$];
  logic [RW-1:0] wDataQ[$];
  logic [7:0]    tx[$];
  bit            fuses[FC];
  logic [RW-1:0] expRows[ROWS];
  logic [15:0]   modelSum;

  gal_fuse_reader dut (
    .C           (C),
    .RN          (RN),
    .START       (START),
    .S_VALID     (S_VALID),
    .S_READY     (S_READY),
    .S_DATA      (S_DATA),
    .W_EN        (W_EN),
    .W_ADDR      (W_ADDR),
    .W_DATA      (W_DATA),
    .EXP_CHECKSUM(EXP_CHECKSUM),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .CHECKSUM    (CHECKSUM),
    .ERR         (ERR)
  );

  always #5 C = ~C;

  always @(negedge C) begin
    if (W_EN) begin
      wAddrQ.push_back(W_ADDR);
      wDataQ.push_back(W_DATA);
      wenCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: a flat fuse array; rows and checksum are read straight out of it.
  task automatic buildModel();
    int sum;
    for (int i = 0; i < FC; i++) fuses[i] = 1'b0;
    for (int i = 0; i < NB; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (8 * i + b < FC) fuses[8 * i + b] = tx[i][b];
      end
    end
    sum = 0;
    for (int f = 0; f < FC; f++) begin
      if (fuses[f]) sum += (1 << (f % 8));
    end
    modelSum = 16'(sum);
    for (int r = 0; r < ROWS; r++) begin
      expRows[r] = '0;
      for (int k = 0; k < RW; k++) begin
        if (r * RW + k < FC) expRows[r][k] = fuses[r * RW + k];
      end
    end
  endtask

  task automatic checkRows(input string tag);
    checkOutput({tag, "_row_count"}, 64'(wAddrQ.size()), 64'(ROWS));
    for (int i = 0; i < wAddrQ.size() && i < ROWS; i++) begin
      checkOutput($sformatf("%s_row%0d_addr", tag, i), 64'(wAddrQ[i]), 64'(i));
      checkOutput($sformatf("%s_row%0d_data", tag, i), 64'(wDataQ[i]), 64'(expRows[i]));
    end
  endtask

  // gapMode 0: every cycle, 1: every other cycle, 2: random gaps.
  task automatic applyStimulus(input string tag, input int gapMode, input int glitchAt,
                               input int abortAt, input bit extraValid, input logic [15:0] expSum);
    int sent, cyc, lat;
    bit v, glitched;
    EXP_CHECKSUM = expSum;
    @(negedge C);
    wAddrQ.delete();
    wDataQ.delete();
    START = 1'b1;
    @(negedge C);
    START = 1'b0;
    checkOutput({tag, "_start_busy"}, 64'(BUSY), 64'(1));
    checkOutput({tag, "_start_done_clr"}, 64'(DONE), 64'(0));
    checkOutput({tag, "_start_sum_clr"}, 64'(CHECKSUM), 64'(0));
    checkOutput({tag, "_start_err_clr"}, 64'(ERR), 64'(0));
    sent = 0;
    cyc = 0;
    glitched = 1'b0;
    while (sent < NB && sent != abortAt && cyc < 5000) begin
      case (gapMode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      START = (!glitched && glitchAt >= 0 && sent == glitchAt);
      if (START) glitched = 1'b1;
      S_VALID = v;
      S_DATA = v ? tx[sent] : 8'h5A;
      if (v && S_READY) sent++;
      cyc++;
      @(negedge C);
    end
    START = 1'b0;
    if (cyc >= 5000) begin
      checkOutput({tag, "_load_timeout"}, 64'(sent), 64'(NB));
      S_VALID = 1'b0;
      return;
    end
    if (sent == abortAt) return;
    S_VALID = extraValid;
    S_DATA = 8'hAA;
    lat = 1;
    while (!DONE && lat < 20) begin
      @(negedge C);
      lat++;
    end
    checkOutput({tag, "_done_latency"}, 64'(lat), 64'(DONE_LAT));
    checkOutput({tag, "_s_ready_fin"}, 64'(S_READY), 64'(0));
    repeat (2) @(negedge C);
    S_VALID = 1'b0;
    checkOutput({tag, "_done"}, 64'(DONE), 64'(1));
    checkOutput({tag, "_busy_fin"}, 64'(BUSY), 64'(0));
    checkOutput({tag, "_checksum"}, 64'(CHECKSUM), 64'(CSUM_ON ? modelSum : 16'h0));
    checkOutput({tag, "_err"}, 64'(ERR), 64'(CSUM_ON && (modelSum != expSum)));
    checkRows(tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_s_ready"}, 64'(S_READY), 64'(0));
    checkOutput({tag, "_w_en"}, 64'(W_EN), 64'(0));
    checkOutput({tag, "_w_addr"}, 64'(W_ADDR), 64'(0));
    checkOutput({tag, "_w_data"}, 64'(W_DATA), 64'(0));
    checkOutput({tag, "_busy"}, 64'(BUSY), 64'(0));
    checkOutput({tag, "_done"}, 64'(DONE), 64'(0));
    checkOutput({tag, "_checksum"}, 64'(CHECKSUM), 64'(0));
    checkOutput({tag, "_err"}, 64'(ERR), 64'(0));
  endtask

  task automatic fillRandom();
    tx.delete();
    for (int i = 0; i < NB; i++) tx.push_back(8'($urandom));
    buildModel();
  endtask

  initial begin
    int snap;
    repeat (3) @(negedge C);
    checkAllZero("reset");
    RN = 1'b1;

    tx.delete();
    for (int i = 0; i < NB; i++) tx.push_back(8'hFF);
    buildModel();
    applyStimulus("ff_match", 0, -1, -1, 1'b0, modelSum);
    applyStimulus("ff_mismatch", 0, -1, -1, 1'b1, modelSum - 16'd1);

    tx.delete();
    for (int i = 0; i < NB; i++) tx.push_back((i < 4) ? 8'(i + 1) : 8'h00);
    buildModel();
    applyStimulus("toggle", 1, -1, -1, 1'b0, modelSum);

    fillRandom();
    applyStimulus("glitch", 2, 50, -1, 1'b1, 16'($urandom));

    fillRandom();
    applyStimulus("abort", 0, -1, 100, 1'b0, modelSum);
    #2 RN = 1'b0;
    #1 checkAllZero("rst_mid");
    snap = wenCount;
    repeat (4) @(negedge C);
    #3 checkOutput("rst_no_wen", 64'(wenCount), 64'(snap));
    S_VALID = 1'b0;
    @(negedge C);
    RN = 1'b1;

    fillRandom();
    applyStimulus("reload", 2, -1, -1, 1'b0, modelSum);

    for (int n = 0; n < 2; n++) begin
      fillRandom();
      applyStimulus($sformatf("rand%0d", n), 2, -1, -1, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0) ? modelSum : 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
